// File: rtl/dm_sysbus_access.sv
// System bus access engine: turns debugger sbaddress/sbdata events into single-beat
// req/gnt/r_valid transactions and reports busy, read data, errors and the
// post-increment address back to the CSR block.
module dm_sysbus_access #(
   parameter int unsigned BusWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  dmactive_i,
   input  logic [BusWidth-1:0]   sbaddress_i,
   output logic [BusWidth-1:0]   sbaddress_o,
   input  logic                  sbaddress_write_valid_i,
   input  logic                  sbreadonaddr_i,
   input  logic                  sbreadondata_i,
   input  logic                  sbautoincrement_i,
   input  logic [2:0]            sbaccess_i,
   input  logic [BusWidth-1:0]   sbdata_i,
   input  logic                  sbdata_read_valid_i,
   input  logic                  sbdata_write_valid_i,
   output logic [BusWidth-1:0]   sbdata_o,
   output logic                  sbdata_valid_o,
   output logic                  sbbusy_o,
   output logic                  sberror_valid_o,
   output logic [2:0]            sberror_o,
   output logic                  master_req_o,
   output logic                  master_we_o,
   output logic [BusWidth-1:0]   master_add_o,
   output logic [BusWidth-1:0]   master_wdata_o,
   output logic [BusWidth/8-1:0] master_be_o,
   input  logic                  master_gnt_i,
   input  logic                  master_r_valid_i,
   input  logic [BusWidth-1:0]   master_r_rdata_i
);

   localparam int unsigned NumBytes = BusWidth / 8;
   localparam int unsigned AddrLsb  = $clog2(NumBytes);
   // Largest legal log2(bytes) equals the number of byte-offset address bits.
   localparam logic [2:0]  MaxSize  = 3'(AddrLsb);

   if (BusWidth != 32 && BusWidth != 64) begin : gen_bad_width
      $error("dm_sysbus_access: BusWidth must be 32 or 64");
   end

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
      StWaitRead,
      StWaitWrite
   } state_e;

   state_e state_q, state_d;

   logic [2:0]          align_mask;
   logic [NumBytes-1:0] lane_mask;
   logic [AddrLsb-1:0]  byte_offset;
   logic                oversize;
   logic                misaligned;

   // Passthrough paths: address, write data and read data are not shifted.
   assign master_add_o   = sbaddress_i;
   assign master_wdata_o = sbdata_i;
   assign sbdata_o       = master_r_rdata_i;
   assign sbbusy_o       = (state_q != StIdle);

   // Size decode: alignment mask, lane mask and byte enables from size and low address bits.
   always_comb begin
      align_mask = 3'b111;
      lane_mask  = '1;
      case (sbaccess_i)
         3'd0: begin
            align_mask = 3'b000;
            lane_mask  = NumBytes'(1);
         end
         3'd1: begin
            align_mask = 3'b001;
            lane_mask  = NumBytes'(3);
         end
         3'd2: begin
            align_mask = 3'b011;
            lane_mask  = NumBytes'(15);
         end
         default: begin
            align_mask = 3'b111;
            lane_mask  = '1;
         end
      endcase
      byte_offset = sbaddress_i[AddrLsb-1:0] & ~align_mask[AddrLsb-1:0];
      master_be_o = lane_mask << byte_offset;
      oversize    = (sbaccess_i > MaxSize);
      misaligned  = |(sbaddress_i[2:0] & align_mask);
   end

   // Next-state and handshake outputs; request outputs depend on state only.
   always_comb begin
      state_d         = state_q;
      master_req_o    = 1'b0;
      master_we_o     = 1'b0;
      sbdata_valid_o  = 1'b0;
      sberror_valid_o = 1'b0;
      sberror_o       = 3'd0;
      sbaddress_o     = sbaddress_i;

      unique case (state_q)
         StRead: begin
            master_req_o = 1'b1;
         end
         StWrite: begin
            master_req_o = 1'b1;
            master_we_o  = 1'b1;
         end
         default: ;
      endcase

      if (dmactive_i) begin
         unique case (state_q)
            StIdle: begin
               if ((sbaddress_write_valid_i && sbreadonaddr_i) || sbdata_write_valid_i ||
                   (sbdata_read_valid_i && sbreadondata_i)) begin
                  if (oversize) begin
                     sberror_valid_o = 1'b1;
                     sberror_o       = 3'd4;
                  end else if (misaligned) begin
                     sberror_valid_o = 1'b1;
                     sberror_o       = 3'd3;
                  end else if (sbaddress_write_valid_i && sbreadonaddr_i) begin
                     state_d = StRead;
                  end else if (sbdata_write_valid_i) begin
                     state_d = StWrite;
                  end else begin
                     state_d = StRead;
                  end
               end
            end
            StRead: begin
               if (master_gnt_i) state_d = StWaitRead;
            end
            StWrite: begin
               if (master_gnt_i) state_d = StWaitWrite;
            end
            StWaitRead: begin
               if (master_r_valid_i) begin
                  sbdata_valid_o = 1'b1;
                  state_d        = StIdle;
                  if (sbautoincrement_i) begin
                     sbaddress_o = sbaddress_i + (BusWidth'(1) << sbaccess_i);
                  end
               end
            end
            StWaitWrite: begin
               if (master_r_valid_i) begin
                  state_d = StIdle;
                  if (sbautoincrement_i) begin
                     sbaddress_o = sbaddress_i + (BusWidth'(1) << sbaccess_i);
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end else begin
         // Debug module deactivated: abandon any transaction, drop the pending response.
         state_d = StIdle;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_dm_sysbus_access.sv
// Bench for dm_sysbus_access: one 32-bit and one 64-bit instance driven from shared stimulus,
// with the unselected instance's triggers gated off.
module tb_dm_sysbus_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmactive;
   logic        sel64;
   logic [63:0] sbaddress, sbdata, rdata;
   logic        addr_wv, readonaddr, readondata, autoinc, data_rv, data_wv, gnt, rvalid;
   logic [2:0]  access;

   logic [31:0] a32, d32, add32, wd32;
   logic [3:0]  be32;
   logic        dv32, busy32, ev32, req32, we32;
   logic [2:0]  e32;
   logic [63:0] a64, d64, add64, wd64;
   logic [7:0]  be64;
   logic        dv64, busy64, ev64, req64, we64;
   logic [2:0]  e64;

   logic [63:0] obs_addr, obs_data, obs_add, obs_wdata;
   logic [7:0]  obs_be;
   logic        obs_dv, obs_busy, obs_ev, obs_req, obs_we;
   logic [2:0]  obs_err;

   logic [63:0] exp_q[$];
   logic [63:0] exp_v;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   dm_sysbus_access #(.BusWidth(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
      .sbaddress_i(sbaddress[31:0]), .sbaddress_o(a32),
      .sbaddress_write_valid_i(addr_wv & ~sel64),
      .sbreadonaddr_i(readonaddr), .sbreadondata_i(readondata),
      .sbautoincrement_i(autoinc), .sbaccess_i(access), .sbdata_i(sbdata[31:0]),
      .sbdata_read_valid_i(data_rv & ~sel64), .sbdata_write_valid_i(data_wv & ~sel64),
      .sbdata_o(d32), .sbdata_valid_o(dv32), .sbbusy_o(busy32),
      .sberror_valid_o(ev32), .sberror_o(e32),
      .master_req_o(req32), .master_we_o(we32), .master_add_o(add32),
      .master_wdata_o(wd32), .master_be_o(be32),
      .master_gnt_i(gnt & ~sel64), .master_r_valid_i(rvalid & ~sel64),
      .master_r_rdata_i(rdata[31:0])
   );

   dm_sysbus_access #(.BusWidth(64)) dut64 (
      .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
      .sbaddress_i(sbaddress), .sbaddress_o(a64),
      .sbaddress_write_valid_i(addr_wv & sel64),
      .sbreadonaddr_i(readonaddr), .sbreadondata_i(readondata),
      .sbautoincrement_i(autoinc), .sbaccess_i(access), .sbdata_i(sbdata),
      .sbdata_read_valid_i(data_rv & sel64), .sbdata_write_valid_i(data_wv & sel64),
      .sbdata_o(d64), .sbdata_valid_o(dv64), .sbbusy_o(busy64),
      .sberror_valid_o(ev64), .sberror_o(e64),
      .master_req_o(req64), .master_we_o(we64), .master_add_o(add64),
      .master_wdata_o(wd64), .master_be_o(be64),
      .master_gnt_i(gnt & sel64), .master_r_valid_i(rvalid & sel64),
      .master_r_rdata_i(rdata)
   );

   // Observe whichever instance is selected.
   always_comb begin
      obs_addr  = sel64 ? a64   : {32'h0, a32};
      obs_data  = sel64 ? d64   : {32'h0, d32};
      obs_add   = sel64 ? add64 : {32'h0, add32};
      obs_wdata = sel64 ? wd64  : {32'h0, wd32};
      obs_be    = sel64 ? be64  : {4'h0, be32};
      obs_dv    = sel64 ? dv64  : dv32;
      obs_busy  = sel64 ? busy64 : busy32;
      obs_ev    = sel64 ? ev64  : ev32;
      obs_req   = sel64 ? req64 : req32;
      obs_we    = sel64 ? we64  : we32;
      obs_err   = sel64 ? e64   : e32;
   end

   task automatic clear_inputs();
      addr_wv = 0; data_wv = 0; data_rv = 0; gnt = 0; rvalid = 0;
      readonaddr = 0; readondata = 0; autoinc = 0; rdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; dmactive = 1; sel64 = 0; sbaddress = '0; sbdata = '0; access = 0;
      clear_inputs();
      #2;
      total++;
      if ({req32, we32, busy32, dv32, ev32, e32} !== 8'h0) begin
         bad++; $display("FAIL reset32: got %b want 0", {req32, we32, busy32, dv32, ev32, e32});
      end
      total++;
      if ({req64, we64, busy64, dv64, ev64, e64} !== 8'h0) begin
         bad++; $display("FAIL reset64: got %b want 0", {req64, we64, busy64, dv64, ev64, e64});
      end
      @(negedge clk); rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_read32();
      @(negedge clk);
      sel64 = 0; sbaddress = 64'h1000; readonaddr = 1; access = 2; addr_wv = 1; #1;
      exp_q.push_back(64'hDEADBEEF);
      total++;
      if (obs_req !== 0 || obs_busy !== 0) begin
         bad++; $display("FAIL rd32_trig: got req=%b busy=%b want 0 0", obs_req, obs_busy);
      end
      @(negedge clk); addr_wv = 0; gnt = 1; #1;
      total++;
      if ({obs_req, obs_we, obs_busy, obs_be} !== {3'b101, 8'h0F} || obs_add !== 64'h1000) begin
         bad++; $display("FAIL rd32_req: got req=%b we=%b busy=%b be=%h add=%h want 1 0 1 0f 1000",
                         obs_req, obs_we, obs_busy, obs_be, obs_add);
      end
      @(negedge clk); gnt = 0; #1;
      total++;
      if (obs_req !== 0 || obs_busy !== 1 || obs_dv !== 0) begin
         bad++; $display("FAIL rd32_wait: got req=%b busy=%b dv=%b want 0 1 0",
                         obs_req, obs_busy, obs_dv);
      end
      @(negedge clk); rvalid = 1; rdata = 64'hDEADBEEF; #1;
      exp_v = exp_q.pop_front();
      total++;
      if (obs_dv !== 1 || obs_data !== exp_v || obs_busy !== 1) begin
         bad++; $display("FAIL rd32_data: got dv=%b data=%h busy=%b want 1 %h 1",
                         obs_dv, obs_data, obs_busy, exp_v);
      end
      @(negedge clk); rvalid = 0; rdata = '0; readonaddr = 0; #1;
      total++;
      if (obs_busy !== 0 || obs_dv !== 0) begin
         bad++; $display("FAIL rd32_done: got busy=%b dv=%b want 0 0", obs_busy, obs_dv);
      end
   endtask

   task automatic test_write_autoinc();
      @(negedge clk);
      sel64 = 0; sbaddress = 64'h1003; sbdata = 64'h55; access = 0; autoinc = 1; data_wv = 1;
      exp_q.push_back(64'h1004);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); data_wv = 0; gnt = (i == 3); #1;
         total++;
         if ({obs_req, obs_we, obs_be} !== {2'b11, 8'h08} || obs_wdata !== 64'h55 ||
             obs_add !== 64'h1003) begin
            bad++; $display("FAIL wr_hold%0d: got req=%b we=%b be=%h wd=%h add=%h want 1 1 08 55 1003",
                            i, obs_req, obs_we, obs_be, obs_wdata, obs_add);
         end
      end
      @(negedge clk); gnt = 0; rvalid = 1; #1;
      exp_v = exp_q.pop_front();
      total++;
      if (obs_addr !== exp_v || obs_dv !== 0 || obs_req !== 0) begin
         bad++; $display("FAIL wr_autoinc: got addr=%h dv=%b req=%b want %h 0 0",
                         obs_addr, obs_dv, obs_req, exp_v);
      end
      @(negedge clk); rvalid = 0; #1;
      total++;
      if (obs_busy !== 0 || obs_addr !== 64'h1003) begin
         bad++; $display("FAIL wr_done: got busy=%b addr=%h want 0 1003", obs_busy, obs_addr);
      end
      autoinc = 0;
   endtask

   task automatic test_errors();
      logic        t_sel [5] = '{0, 0, 0, 1, 1};
      logic        t_aw  [5] = '{0, 1, 0, 0, 0};
      logic [63:0] t_addr[5] = '{64'h1000, 64'h1001, 64'h1001, 64'h1002, 64'h1000};
      logic [2:0]  t_acc [5] = '{3'd3, 3'd1, 3'd3, 3'd2, 3'd4};
      logic [2:0]  t_code[5] = '{3'd4, 3'd3, 3'd4, 3'd3, 3'd4};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sel64 = t_sel[i]; sbaddress = t_addr[i]; access = t_acc[i];
         readonaddr = t_aw[i]; addr_wv = t_aw[i]; data_wv = ~t_aw[i];
         exp_q.push_back({61'h0, t_code[i]});
         #1;
         exp_v = exp_q.pop_front();
         total++;
         if (obs_ev !== 1 || obs_err !== exp_v[2:0] || obs_req !== 0) begin
            bad++; $display("FAIL err%0d: got ev=%b code=%0d req=%b want 1 %0d 0",
                            i, obs_ev, obs_err, obs_req, exp_v[2:0]);
         end
         @(negedge clk); addr_wv = 0; data_wv = 0; readonaddr = 0; #1;
         total++;
         if (obs_busy !== 0 || obs_req !== 0 || obs_ev !== 0) begin
            bad++; $display("FAIL err%0d_after: got busy=%b req=%b ev=%b want 0 0 0",
                            i, obs_busy, obs_req, obs_ev);
         end
      end
      sel64 = 0;
   endtask

   task automatic read64(input logic [63:0] addr, input logic [63:0] data,
                         input logic [63:0] next_addr, input string tag);
      @(negedge clk);
      sel64 = 1; sbaddress = addr; access = 2; readondata = 1; data_rv = 1; autoinc = 1;
      exp_q.push_back(data);
      exp_q.push_back(next_addr);
      #1;
      @(negedge clk); data_rv = 0; gnt = 1; #1;
      total++;
      if (obs_req !== 1 || obs_we !== 0 || obs_be !== 8'hF0) begin
         bad++; $display("FAIL %s_be: got req=%b we=%b be=%h want 1 0 f0",
                         tag, obs_req, obs_we, obs_be);
      end
      @(negedge clk); gnt = 0; rvalid = 1; rdata = data; #1;
      exp_v = exp_q.pop_front();
      total++;
      if (obs_dv !== 1 || obs_data !== exp_v) begin
         bad++; $display("FAIL %s_data: got dv=%b data=%h want 1 %h", tag, obs_dv, obs_data, exp_v);
      end
      exp_v = exp_q.pop_front();
      total++;
      if (obs_addr !== exp_v) begin
         bad++; $display("FAIL %s_inc: got addr=%h want %h", tag, obs_addr, exp_v);
      end
      @(negedge clk); rvalid = 0; readondata = 0; autoinc = 0; #1;
   endtask

   task automatic test_bus64();
      read64(64'h0000_0000_8000_0004, 64'h1122_3344_5566_7788, 64'h0000_0000_8000_0008, "rd64");
      read64(64'hFFFF_FFFF_FFFF_FFFC, 64'h0BAD_F00D_1234_5678, 64'h0, "wrap64");
      // Byte write on lane 5.
      @(negedge clk); sel64 = 1; sbaddress = 64'h1005; access = 0; data_wv = 1; #1;
      @(negedge clk); data_wv = 0; gnt = 1; #1;
      total++;
      if (obs_be !== 8'h20 || obs_we !== 1) begin
         bad++; $display("FAIL be64_byte: got be=%h we=%b want 20 1", obs_be, obs_we);
      end
      @(negedge clk); gnt = 0; rvalid = 1; #1;
      @(negedge clk); rvalid = 0; #1;
      sel64 = 0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk); sel64 = 0; sbaddress = 64'h2000; access = 2; readonaddr = 1; addr_wv = 1;
      exp_q.push_back(64'hCAFEF00D);
      #1;
      @(negedge clk); addr_wv = 0; readonaddr = 0; gnt = 1; data_wv = 1; #1;
      @(negedge clk); gnt = 0; data_wv = 0; rvalid = 1; rdata = 64'hCAFEF00D; #1;
      exp_v = exp_q.pop_front();
      total++;
      if (obs_dv !== 1 || obs_data !== exp_v) begin
         bad++; $display("FAIL b2b_data: got dv=%b data=%h want 1 %h", obs_dv, obs_data, exp_v);
      end
      @(negedge clk); rvalid = 0; sbaddress = 64'h2004; sbdata = 64'h77; data_wv = 1; #1;
      total++;
      if (obs_busy !== 0 || obs_req !== 0) begin
         bad++; $display("FAIL b2b_idle: got busy=%b req=%b want 0 0", obs_busy, obs_req);
      end
      @(negedge clk); data_wv = 0; gnt = 1; #1;
      total++;
      if (obs_req !== 1 || obs_we !== 1 || obs_wdata !== 64'h77) begin
         bad++; $display("FAIL b2b_req: got req=%b we=%b wd=%h want 1 1 77",
                         obs_req, obs_we, obs_wdata);
      end
      @(negedge clk); gnt = 0; rvalid = 1; #1;
      @(negedge clk); rvalid = 0; #1;
      total++;
      if (obs_busy !== 0) begin
         bad++; $display("FAIL b2b_done: got busy=%b want 0", obs_busy);
      end
   endtask

   task automatic test_dmactive();
      // Drop while waiting for the response; the late response must be ignored.
      @(negedge clk); sel64 = 0; sbaddress = 64'h3000; access = 2; readonaddr = 1; addr_wv = 1; #1;
      @(negedge clk); addr_wv = 0; readonaddr = 0; gnt = 1; #1;
      @(negedge clk); gnt = 0; dmactive = 0; #1;
      total++;
      if (obs_busy !== 1) begin
         bad++; $display("FAIL dm_waitread: got busy=%b want 1", obs_busy);
      end
      @(negedge clk); dmactive = 1; rvalid = 1; rdata = 64'h1234; #1;
      total++;
      if (obs_busy !== 0 || obs_req !== 0 || obs_dv !== 0) begin
         bad++; $display("FAIL dm_abort: got busy=%b req=%b dv=%b want 0 0 0",
                         obs_busy, obs_req, obs_dv);
      end
      @(negedge clk); rvalid = 0; #1;
      // Drop while requesting: request withdrawn the next cycle.
      @(negedge clk); sbaddress = 64'h3004; sbdata = 64'h9; data_wv = 1; #1;
      @(negedge clk); data_wv = 0; dmactive = 0; #1;
      total++;
      if (obs_req !== 1) begin
         bad++; $display("FAIL dm_req_before: got req=%b want 1", obs_req);
      end
      @(negedge clk); dmactive = 1; #1;
      total++;
      if (obs_req !== 0 || obs_busy !== 0) begin
         bad++; $display("FAIL dm_req_after: got req=%b busy=%b want 0 0", obs_req, obs_busy);
      end
   endtask

   initial begin
      test_reset();
      test_read32();
      test_write_autoinc();
      test_errors();
      test_bus64();
      test_back_to_back();
      test_dmactive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_sysbus_access.md
# dm_sysbus_access

System Bus Access (SBA) engine of the RISC-V debug module. It turns debugger-initiated `sbaddress`/`sbdata` CSR events into single-beat transactions on the debug module's system-bus master port. It sits between the DM CSR block, which owns the `sbcs`/`sbaddress`/`sbdata` registers, and the SoC interconnect, which uses a req/gnt/r_valid protocol. It reports busy, read data, error and post-increment address back to the CSR block.

## Interface
- `BusWidth`, default 32: bus/address/data width; only 32 or 64 are legal, any other value is an elaboration error.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `dmactive_i` in 1: DM active; when low, the engine is held/returned to Idle.
- `sbaddress_i` in BusWidth: current sbaddress CSR value.
- `sbaddress_o` out BusWidth: address for the CSR block to load back every cycle.
- `sbaddress_write_valid_i` in 1: debugger wrote sbaddress this cycle.
- `sbreadonaddr_i`, `sbreadondata_i`, `sbautoincrement_i` in 1: sbcs control bits.
- `sbaccess_i` in 3: access size as log2(bytes).
- `sbdata_i` in BusWidth: write data.
- `sbdata_read_valid_i`, `sbdata_write_valid_i` in 1: debugger read / wrote sbdata0.
- `sbdata_o` out BusWidth: read data.
- `sbdata_valid_o` out 1: one-cycle pulse; `sbdata_o` is valid.
- `sbbusy_o` out 1: a transaction is in flight.
- `sberror_valid_o` out 1: one-cycle pulse; `sberror_o` is valid.
- `sberror_o` out 3: sberror code.
- `master_req_o`, `master_we_o` out 1; `master_add_o`, `master_wdata_o` out BusWidth; `master_be_o` out BusWidth/8: bus request.
- `master_gnt_i`, `master_r_valid_i` in 1; `master_r_rdata_i` in BusWidth: bus response.

## Operation
- States: Idle, Read, Write, WaitRead, WaitWrite.
- Triggers, evaluated only in Idle, in priority order:
  - `sbaddress_write_valid_i & sbreadonaddr_i` → Read.
  - `sbdata_write_valid_i` → Write.
  - `sbdata_read_valid_i & sbreadondata_i` → Read.
- Size check at trigger time. The maximum size is 2 for BusWidth 32 and 3 for BusWidth 64.
  - `sbaccess_i` above the maximum: pulse `sberror_valid_o` with `sberror_o` = 4, stay Idle, no bus request.
  - `sbaddress_i` not aligned to 1<<`sbaccess_i`: `sberror_o` = 3, same handling.
  - Oversize takes priority over misalignment.
- Read and Write states:
  - `master_req_o` = 1; `master_we_o` = 1 only in Write.
  - On `master_gnt_i`, go to WaitRead / WaitWrite respectively.
- WaitRead: on `master_r_valid_i`, pulse `sbdata_valid_o` and go to Idle.
- WaitWrite: on `master_r_valid_i`, go to Idle.
- `sbdata_o` = `master_r_rdata_i`, unshifted; it is meaningful only while `sbdata_valid_o` is high.
- `master_add_o` = `sbaddress_i`; `master_wdata_o` = `sbdata_i`, passthrough.
- `master_be_o` is set by size and the low address bits:
  - BusWidth 32: size 0 → one bit at addr[1:0]; size 1 → two bits at 2·addr[1]; size 2 → 4'hF.
  - BusWidth 64: size 0 → one bit at addr[2:0]; size 1 → two bits at 2·addr[2:1]; size 2 → four bits at 4·addr[2]; size 3 → 8'hFF.
- `sbaddress_o` = `sbaddress_i`, except in the completion cycle (r_valid seen in WaitRead/WaitWrite) with `sbautoincrement_i` = 1. In that cycle it is `sbaddress_i + (1 << sbaccess_i)`, modulo 2^BusWidth (wraps).
- `sbbusy_o` = (state != Idle), combinational from state.
- `dmactive_i` = 0: next state Idle from any state. Request outputs depend only on state, so the request drops the following cycle. An outstanding response is ignored.

## Timing
- Reset values: state Idle; `master_req_o`, `master_we_o`, `sbbusy_o`, `sbdata_valid_o`, `sberror_valid_o` = 0; `sberror_o` = 0.
- Trigger in cycle T → `master_req_o` and `sbbusy_o` high from T+1.
- The request is held until a cycle with `master_gnt_i` = 1. `master_add_o`, `master_be_o` and `master_wdata_o` must stay stable meanwhile.
- `master_r_valid_i` is accepted only in the Wait states, i.e. earliest one cycle after the grant.
- With gnt at T+1 and r_valid at T+2: `sbdata_valid_o` pulses at T+2, `sbbusy_o` drops at T+3, and a new trigger is accepted at T+3.
- Errors are combinational in the trigger cycle T; `sbbusy_o` never rises for them.
- Triggers arriving while not Idle are ignored. The CSR block flags `sbbusyerror`.

## Test plan
- BusWidth 32, sbaddress 0x1000, readonaddr = 1, sbaccess = 2, addr write; gnt at T+1, r_valid with 0xDEADBEEF at T+3 → req at T+1 with be 0xF and we 0; sbdata_valid pulse at T+3 with sbdata_o 0xDEADBEEF; busy T+1..T+3.
- sbdata write 0x55 at sbaddress 0x1003, sbaccess = 0, autoincrement = 1; gnt delayed 3 cycles → we = 1, be = 0x8, req held 4 cycles; sbaddress_o = 0x1004 in the completion cycle.
- sbaccess = 3 on BusWidth 32 write trigger → sberror_valid pulse with code 4, no req, sbbusy stays 0.
- sbaccess = 1 at address 0x1001 → sberror = 3, no req.
- BusWidth 64, sbaccess = 2, address 0x…4, readondata read → be = 0xF0; autoincrement with address 0xFFFF_FFFF_FFFF_FFFC wraps sbaddress_o to 0.
- dmactive_i dropped in WaitRead → Idle next cycle, sbbusy 0, and a later r_valid produces no sbdata_valid.
